// File: rtl/io_bus_bridge.sv
// CPU-side bus bridge: decodes a byte bus into RAM or a small IO page
// (UART RX/TX, free-running cycle counter, stop flag).
module io_bus_bridge #(
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        ram_en,
  output logic        ram_wr,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [17:0] A_DATA = 18'h30000;
  localparam logic [17:0] A_CNT  = 18'h30004;

  logic [17:0] addr;
  logic        unused_hi;
  logic        io_sel, io_rd, io_wr, ram_rd, data_sel, cnt_sel;

  assign addr      = mem_a[17:0];
  assign unused_hi = ^mem_a[31:18];
  assign io_sel    = rdy_in & (addr[17:16] == 2'b11);
  assign io_rd     = io_sel & ~mem_wr;
  assign io_wr     = io_sel & mem_wr;
  assign data_sel  = (addr == A_DATA);
  assign cnt_sel   = (addr[17:2] == A_CNT[17:2]);

  assign ram_en    = rdy_in & (addr[17:16] != 2'b11);
  assign ram_wr    = mem_wr;
  assign ram_a     = addr[16:0];
  assign ram_wdata = mem_dout;
  assign ram_rd    = ram_en & ~mem_wr;

  // rx_pop is combinational, so it must be forced low while held in reset
  assign rx_pop = io_rd & data_sel & rx_valid & rst_in;

  // Cycle counter and snapshot
  logic [31:0] cycle_cnt, snap;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt <= '0;
      snap      <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (io_rd && cnt_sel && addr[1:0] == 2'b00) snap <= cycle_cnt;
    end
  end

  // Read data for the IO page; bytes 1-3 come from the snapshot so a
  // multi-byte read never tears across a carry.
  logic [7:0] io_rdata;

  always_comb begin
    io_rdata = 8'h00;
    if (io_rd) begin
      if (data_sel) begin
        if (rx_valid) io_rdata = rx_data;
      end else if (cnt_sel) begin
        case (addr[1:0])
          2'd0:    io_rdata = cycle_cnt[7:0];
          2'd1:    io_rdata = snap[15:8];
          2'd2:    io_rdata = snap[23:16];
          default: io_rdata = snap[31:24];
        endcase
      end
    end
  end

  logic       src_ram;
  logic [7:0] io_byte;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      src_ram <= 1'b0;
      io_byte <= 8'h00;
    end else begin
      src_ram <= ram_rd;
      io_byte <= io_rdata;
    end
  end

  assign mem_din = src_ram ? ram_rdata : io_byte;

  // TX FIFO
  logic [TX_DEPTH-1:0][7:0] fifo_mem;
  logic [AW-1:0]            head, tail;
  logic [CW-1:0]            count;
  logic                     push_req, push, pop, full, stop_wr;
  logic [7:0]               push_data;

  assign stop_wr   = io_wr & (addr == A_CNT);
  assign push_req  = (io_wr & data_sel & (mem_dout != 8'h00)) | stop_wr;
  assign push_data = stop_wr ? 8'h00 : mem_dout;
  assign full      = (count == CW'(TX_DEPTH));
  assign pop       = tx_valid & tx_ready;
  assign push      = push_req & (~full | pop);

  assign tx_valid       = (count != '0);
  assign tx_data        = fifo_mem[head];
  assign io_buffer_full = (TX_DEPTH - int'(count)) < FULL_MARGIN;

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[tail] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      program_stop <= 1'b0;
    end else begin
      if (pop)  head <= head + AW'(1);
      if (push) tail <= tail + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (stop_wr) program_stop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_io_bus_bridge.sv
// Bench for io_bus_bridge: directed scenarios plus random traffic checked
// against a queue/arithmetic reference model.
module tb_io_bus_bridge;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full, ram_en, ram_wr;
  logic [16:0] ram_a;
  logic [7:0]  ram_wdata, ram_rdata = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, rx_pop, program_stop;

  io_bus_bridge #(.TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .ram_en(ram_en), .ram_wr(ram_wr),
    .ram_a(ram_a), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_stop(program_stop)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [7:0]  q[$];
  logic [7:0]  dut_log[$];
  int unsigned cnt_m, snap_m;
  bit          stop_m;
  int          pend;
  logic [7:0]  pend_val, last_din;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic bus(input bit rdy, input logic [31:0] a, input bit wr, input logic [7:0] d);
    rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = d;
  endtask

  task automatic model_reset();
    q.delete(); cnt_m = 0; snap_m = 0; stop_m = 0; pend = 0;
  endtask

  // One clock: inputs are already driven (just after negedge).
  task automatic step();
    logic [17:0] a;
    bit          io, ram, pop, push, ok, take;
    int          npend;
    logic [7:0]  nval, pdata;
    #2;
    a  = mem_a[17:0];
    io = rdy_in && a[17:16] == 2'b11;
    ram = rdy_in && !io;
    last_din = mem_din;
    chk("ram_en", ram_en, ram);
    if (ram) begin
      chk("ram_wr", ram_wr, mem_wr);
      chk("ram_a", ram_a, a[16:0]);
      chk("ram_wdata", ram_wdata, mem_dout);
    end
    chk("rx_pop", rx_pop, io && !mem_wr && a == 18'h30000 && rx_valid);
    chk("tx_valid", tx_valid, q.size() != 0);
    if (q.size() != 0) chk("tx_data", tx_data, q[0]);
    chk("io_buffer_full", io_buffer_full, (DEPTH - q.size()) < MARGIN);
    chk("program_stop", program_stop, stop_m);
    if (pend == 1) chk("mem_din_ram", mem_din, ram_rdata);
    if (pend == 2) chk("mem_din_io", mem_din, pend_val);
    if (tx_valid && tx_ready) dut_log.push_back(tx_data);

    npend = 0; nval = 0; take = 0; push = 0; pdata = 0;
    if (ram && !mem_wr) npend = 1;
    if (io && !mem_wr) begin
      npend = 2;
      if (a == 18'h30000) nval = rx_valid ? rx_data : 8'h00;
      else if (a >= 18'h30004 && a <= 18'h30007) begin
        case (a - 18'h30004)
          0: begin nval = cnt_m % 256; take = 1; end
          1: nval = (snap_m / 256) % 256;
          2: nval = (snap_m / 65536) % 256;
          default: nval = snap_m / 16777216;
        endcase
      end
    end
    if (io && mem_wr) begin
      if (a == 18'h30000 && mem_dout != 0) begin push = 1; pdata = mem_dout; end
      if (a == 18'h30004) push = 1;
    end
    pop = q.size() != 0 && tx_ready;
    ok  = push && (q.size() < DEPTH || pop);
    @(posedge clk_in);
    if (pop) void'(q.pop_front());
    if (ok) q.push_back(pdata);
    if (take) snap_m = cnt_m;
    if (io && mem_wr && a == 18'h30004) stop_m = 1;
    cnt_m = cnt_m + 1;
    pend = npend; pend_val = nval;
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    bus(0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    int base, r;
    logic [31:0] a;
    // Reset values, with an IO read of the RX port pending on the bus
    bus(1, 32'h30000, 0, 0); rx_valid = 1; rx_data = 8'h5A; tx_ready = 1;
    repeat (2) @(negedge clk_in);
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_full", io_buffer_full, 1'b0);
    chk("rst_stop", program_stop, 1'b0);
    bus(0, 0, 0, 0); rx_valid = 0; tx_ready = 0;
    model_reset();
    rst_in = 1;

    // Snapshot across a low-byte carry: counter reads 0x1FF at the first read
    repeat (511) step();
    bus(1, 32'h30004, 0, 0); step();
    bus(1, 32'h30005, 0, 0); step(); chk("snap_b0", last_din, 8'hFF);
    bus(1, 32'h30006, 0, 0); step(); chk("snap_b1", last_din, 8'h01);
    bus(1, 32'h30007, 0, 0); step(); chk("snap_b2", last_din, 8'h00);
    idle(1);                          chk("snap_b3", last_din, 8'h00);

    // 0x41 then 0x00 to the TX port: exactly one beat
    tx_ready = 1; base = dut_log.size();
    bus(1, 32'h30000, 1, 8'h41); step();
    bus(1, 32'h30000, 1, 8'h00); step();
    idle(4);
    chk("tx_beats", dut_log.size() - base, 1);
    chk("tx_byte", dut_log[base], 8'h41);

    // RAM read of 0x10 returns ram_rdata next cycle
    bus(1, 32'h00010, 0, 0); step();
    ram_rdata = 8'hA5; idle(1);
    chk("ram_rd", last_din, 8'hA5);

    // Fill with tx_ready low: full flag after 7th, 9th/10th dropped
    tx_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      bus(1, 32'h30000, 1, 8'(i)); step();
      if (i == 6) chk("full_at6", io_buffer_full, 1'b0);
      if (i == 7) chk("full_at7", io_buffer_full, 1'b1);
    end
    tx_ready = 1; base = dut_log.size(); idle(10);
    chk("fill_beats", dut_log.size() - base, 8);
    for (int i = 0; i < 8; i++) chk("fill_order", dut_log[base + i], 8'(i + 1));

    // Push into a full FIFO while it pops
    tx_ready = 0;
    for (int i = 0; i < 8; i++) begin bus(1, 32'h30000, 1, 8'h11 + 8'(i)); step(); end
    tx_ready = 1; base = dut_log.size();
    bus(1, 32'h30000, 1, 8'h19); step();
    chk("full_pp", io_buffer_full, 1'b1);
    idle(10);
    chk("pp_beats", dut_log.size() - base, 9);
    chk("pp_last", dut_log[dut_log.size() - 1], 8'h19);

    // rdy low ignores IO write; then stop write
    tx_ready = 0;
    bus(0, 32'h30000, 1, 8'h55); step();
    chk("rdy0_nopush", tx_valid, 1'b0);
    bus(1, 32'h30004, 1, 8'h77); step();
    chk("stop_set", program_stop, 1'b1);
    tx_ready = 1; base = dut_log.size(); idle(3);
    chk("stop_beats", dut_log.size() - base, 1);
    chk("stop_byte", dut_log[base], 8'h00);

    // Asynchronous reset while draining
    tx_ready = 0;
    for (int i = 0; i < 4; i++) begin bus(1, 32'h30000, 1, 8'hC0 + 8'(i)); step(); end
    tx_ready = 1; bus(1, 32'h30000, 0, 0); rx_valid = 1; step();
    #2 rst_in = 0;
    #1;
    chk("async_tx_valid", tx_valid, 1'b0);
    chk("async_full", io_buffer_full, 1'b0);
    chk("async_stop", program_stop, 1'b0);
    chk("async_din", mem_din, 8'h00);
    chk("async_rx_pop", rx_pop, 1'b0);
    @(negedge clk_in);
    model_reset(); bus(0, 0, 0, 0); rx_valid = 0; rst_in = 1;

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom & 32'hFFFC_0000;
      case (r)
        0, 1, 2: a = $urandom & 32'hFFFE_FFFF;
        3:       a = a | 32'h30000;
        4, 5, 6, 7: a = a | (32'h30004 + 32'(r - 4));
        8:       a = a | 32'h30008 | ($urandom & 32'h0FF8);
        default: a = a | 32'h30000 | ($urandom & 32'hFFFF);
      endcase
      bus($urandom_range(0, 99) < 85, a, $urandom_range(0, 1),
          ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      tx_ready  = $urandom_range(0, 1);
      rx_valid  = $urandom_range(0, 1);
      rx_data   = 8'($urandom);
      ram_rdata = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
